// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: takes a binary value over valid/ready and converts it to
// BCD with a serial double-dabble engine (one shift per clock). It latches the
// digits into display registers and drives NUM_DIGITS seven_seg decoders.
// Values above 10^NUM_DIGITS-1 are flagged on overflow and shown as dashes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.

// Single-digit active-low decoder. Priority is dash, then blank, then digit.
// Segment order is {g,f,e,d,c,b,a}.
module seven_seg (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);
  // Decode the digit, with dash and blank overriding it
  always_comb begin
    seg_o = 7'b1111111;
    if (dash_i) begin
      seg_o = 7'b0111111;
    end else if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = 7'b1000000;
        4'd1:    seg_o = 7'b1111001;
        4'd2:    seg_o = 7'b0100100;
        4'd3:    seg_o = 7'b0110000;
        4'd4:    seg_o = 7'b0011001;
        4'd5:    seg_o = 7'b0010010;
        4'd6:    seg_o = 7'b0000010;
        4'd7:    seg_o = 7'b1111000;
        4'd8:    seg_o = 7'b0000000;
        4'd9:    seg_o = 7'b0010000;
        default: seg_o = 7'b1111111;
      endcase
    end
  end
endmodule

module seg_display_ctrl #(
  parameter int WIDTH      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_value,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * NUM_DIGITS;

  function automatic longint unsigned pow10m1(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  localparam longint unsigned MAXV = pow10m1(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e                         state_q, state_d;
  logic [WIDTH-1:0]               bin_q, bin_d;
  logic [NUM_DIGITS-1:0][3:0]     bcd_q, bcd_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           ovf_pend_q, ovf_pend_d;
  logic [NUM_DIGITS-1:0][3:0]     disp_q, disp_d;
  logic                           ovf_q, ovf_d;

  logic [NUM_DIGITS-1:0][3:0]     bcd_adj;
  logic [NUM_DIGITS-1:0][3:0]     bcd_sh;
  logic [WIDTH-1:0]               bin_sh;
  logic [BW+WIDTH-1:0]            sh;
  logic                           in_ovf;
  logic [NUM_DIGITS-1:0]          blank;

  // The range check uses the full input width, so carries lost off the top
  // BCD nibble never matter: those values are already flagged here.
  assign in_ovf = (64'(in_value) > MAXV);

  // One double-dabble step: +3 on every nibble >= 5, then shift {bcd,bin} left
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    sh     = {bcd_adj, bin_q} << 1;
    bcd_sh = sh[BW+WIDTH-1:WIDTH];
    bin_sh = sh[WIDTH-1:0];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state: accept in IDLE, WIDTH shifts, display update on the last one
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_value;
          bcd_d      = '0;
          cnt_d      = CW'(WIDTH);
          ovf_pend_d = in_ovf;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_sh;
        bcd_d = bcd_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Display registers change only here, so hex is stable during SHIFT
          disp_d  = bcd_sh;
          ovf_d   = ovf_pend_q;
          state_d = LATCH;
        end
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT) || (state_q == LATCH);
  assign done     = (state_q == LATCH);
  assign overflow = ovf_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Blank digit i>0 when it and every digit above it are zero; dashes win
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic z;
      z = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++)
        if (disp_q[j] != 4'd0) z = 1'b0;
      blank[i] = (i != 0) && z && !ovf_q;
    end
  end
`else
  // Every digit is always decoded
  always_comb begin
    blank = '0;
  end
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    seven_seg u_seg (
      .digit_i (disp_q[g]),
      .blank_i (blank[g]),
      .dash_i  (ovf_q),
      .seg_o   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Table-driven bench for seg_display_ctrl with hand-computed segment codes,
// plus directed sequences for hold-off during SHIFT and mid-conversion reset.
module tb_seg_display_ctrl;
  localparam int WIDTH = 14;
  localparam int ND    = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111, SD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SB;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             busy, done, overflow;
  logic [7*ND-1:0]  hex;

  seg_display_ctrl #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .busy(busy), .done(done), .overflow(overflow),
    .hex(hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic [27:0]      hex;
    logic             ovf;
  } vec_t;

  vec_t tbl[9];
  int   ncmp = 0;
  int   nerr = 0;
  logic [27:0] rst_hex;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Accept one value, then watch for the done pulse and check the result
  task automatic convert(input logic [WIDTH-1:0] val, input logic [27:0] exp_hex,
                         input logic exp_ovf);
    logic [27:0] prev;
    int  k;
    bit  seen, glitch;
    k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    in_valid = 1'b1; in_value = val; prev = hex;
    @(posedge clk); #1;
    in_valid = 1'b0; in_value = ~val;   // later changes must not matter
    check($sformatf("busy_after_accept_%0d", val), 32'(busy), 32'd1);
    seen = 0; glitch = 0; k = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1; k++;
      if (done) seen = 1;
      else if (hex !== prev) glitch = 1;
    end
    check($sformatf("done_latency_%0d", val), 32'(k), 32'd14);
    check($sformatf("no_glitch_%0d", val), 32'(glitch), 32'd0);
    check($sformatf("hex_%0d", val), 32'(hex), 32'(exp_hex));
    check($sformatf("ovf_%0d", val), 32'(overflow), 32'(exp_ovf));
    check($sformatf("busy_latch_%0d", val), 32'(busy), 32'd1);
    @(posedge clk); #1;
    check($sformatf("idle_ready_%0d", val), {29'd0, in_ready, busy, done}, 32'b100);
  endtask

  initial begin
    int k;
    bit got_done;
    rst_hex = {LZ, LZ, LZ, S0};
    tbl[0] = '{14'd1234,  {S1, S2, S3, S4}, 1'b0};
    tbl[1] = '{14'd7,     {LZ, LZ, LZ, S7}, 1'b0};
    tbl[2] = '{14'd10000, {SD, SD, SD, SD}, 1'b1};
    tbl[3] = '{14'd42,    {LZ, LZ, S4, S2}, 1'b0};
    tbl[4] = '{14'd0,     {LZ, LZ, LZ, S0}, 1'b0};
    tbl[5] = '{14'd9999,  {S9, S9, S9, S9}, 1'b0};
    tbl[6] = '{14'd100,   {LZ, S1, S0, S0}, 1'b0};
    tbl[7] = '{14'd1005,  {S1, S0, S0, S5}, 1'b0};
    tbl[8] = '{14'd16383, {SD, SD, SD, SD}, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_value = '0;
    #2;
    check("reset_ctrl", {28'd0, in_ready, busy, done, overflow}, 32'b1000);
    check("reset_hex", 32'(hex), 32'(rst_hex));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ctrl", {28'd0, in_ready, busy, done, overflow}, 32'b1000);
    check("post_reset_hex", 32'(hex), 32'(rst_hex));

    for (int i = 0; i < 9; i++) convert(tbl[i].val, tbl[i].hex, tbl[i].ovf);

    // Hold in_valid through SHIFT with a new value: no second accept until IDLE
    @(negedge clk);
    in_valid = 1'b1; in_value = 14'd1234;
    @(posedge clk); #1;
    in_value = 14'd9999;
    k = 0; got_done = 0;
    while (!got_done && k < 40) begin
      @(posedge clk); #1; k++;
      if (done) got_done = 1;
      else if (in_ready) check("hold_no_early_ready", 32'(in_ready), 32'd0);
    end
    check("hold_first_latency", 32'(k), 32'd14);
    check("hold_first_hex", 32'(hex), 32'({S1, S2, S3, S4}));
    @(posedge clk); #1;
    check("hold_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("hold_second_accept", {30'd0, in_ready, busy}, 32'b01);
    in_valid = 1'b0;
    k = 0; got_done = 0;
    while (!got_done && k < 40) begin
      @(posedge clk); #1; k++;
      if (done) got_done = 1;
    end
    check("hold_second_latency", 32'(k), 32'd14);
    check("hold_second_hex", 32'(hex), 32'({S9, S9, S9, S9}));
    @(posedge clk); #1;

    // Set overflow so the reset visibly clears it, then reset at shift 6
    convert(14'd12000, {SD, SD, SD, SD}, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_value = 14'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {28'd0, in_ready, busy, done, overflow}, 32'b1000);
    check("midrst_hex", 32'(hex), 32'(rst_hex));
    @(negedge clk); rst_n = 1'b1;
    got_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) got_done = 1;
    end
    check("midrst_no_done", 32'(got_done), 32'd0);
    check("midrst_hex_after", 32'(hex), 32'(rst_hex));
    check("midrst_ready_after", {30'd0, in_ready, overflow}, 32'b10);

    convert(14'd5678, {S5, 7'b0000010, S7, 7'b0000000}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
endmodule
